// File: rtl/dram_app_responder.sv
// dram_app_responder
// Behavioural stand-in for a DRAM controller/PHY on the application command/data port.
// It emulates calibration and serves two-beat write/read bursts from an internal RAM that
// holds one burst (two app beats) per address. Used in simulation and in DRAM-less FPGA builds.
//
// Ports
//   dram_clk0       sole clock
//   dram_rst_i      synchronous active-high reset (RAM contents survive it)
//   dram_cmd_valid  command strobe, one cycle per command
//   dram_cmd_rnw    1 = read, 0 = write
//   dram_cmd_addr   burst address, low ADDR_BITS bits index the RAM
//   dram_wr_data    write beat0 on the command cycle, beat1 on the following cycle
//   dram_wr_be      per-byte write enables for the beat presented this cycle
//   dram_rd_data    read beat (beat0 = low half, then beat1 = high half), 0 when not valid
//   dram_rd_valid   high for two consecutive cycles per accepted read
//   dram_phy_rdy    calibration finished successfully
//   dram_cal_fail   calibration finished with failure
//   cmd_err_count   saturating count of dropped commands
module dram_app_responder #(
  parameter int unsigned DQ_WIDTH   = 72,
  parameter int unsigned ADDR_BITS  = 6,
  parameter int unsigned RD_LATENCY = 4,
  parameter int unsigned CAL_CYCLES = 64,
  parameter bit          CAL_FAIL   = 1'b0
) (
  input  logic                    dram_clk0,
  input  logic                    dram_rst_i,
  input  logic                    dram_cmd_valid,
  input  logic                    dram_cmd_rnw,
  input  logic [31:0]             dram_cmd_addr,
  input  logic [2*DQ_WIDTH-1:0]   dram_wr_data,
  input  logic [2*DQ_WIDTH/8-1:0] dram_wr_be,
  output logic [2*DQ_WIDTH-1:0]   dram_rd_data,
  output logic                    dram_rd_valid,
  output logic                    dram_phy_rdy,
  output logic                    dram_cal_fail,
  output logic [15:0]             cmd_err_count
);

  localparam int unsigned BeatW  = 2 * DQ_WIDTH;
  localparam int unsigned BurstW = 2 * BeatW;
  localparam int unsigned BeW    = BeatW / 8;
  localparam int unsigned Depth  = 1 << ADDR_BITS;
  localparam int unsigned CntW   = $clog2(CAL_CYCLES + 1);

  typedef enum logic [1:0] {StCal, StReady, StFail} cal_state_e;

  cal_state_e            state_q, state_d;
  logic [CntW-1:0]       cal_cnt_q, cal_cnt_d;
  logic                  busy_q;     // a command was accepted last cycle
  logic                  wr_hi_q;    // this cycle carries write beat1
  logic [ADDR_BITS-1:0]  wr_addr_q;
  logic [15:0]           err_q, err_d;
  logic [RD_LATENCY-1:0] rd_v_q, rd_v_d;
  logic [BurstW-1:0]     rd_d_q [RD_LATENCY];
  logic                  b1_v_q;
  logic [BeatW-1:0]      b1_d_q;
  logic [BurstW-1:0]     mem [Depth];

  logic [ADDR_BITS-1:0]  cmd_idx;
  logic                  acc, acc_wr, acc_rd;
  logic                  unused_addr_hi;

  assign cmd_idx        = dram_cmd_addr[ADDR_BITS-1:0];
  assign unused_addr_hi = ^dram_cmd_addr[31:ADDR_BITS];

  // Calibration FSM: counts from reset release, then parks in a terminal state.
  always_comb begin
    state_d   = state_q;
    cal_cnt_d = cal_cnt_q;
    if (state_q == StCal) begin
      cal_cnt_d = cal_cnt_q + CntW'(1);
      if (cal_cnt_d == CntW'(CAL_CYCLES)) begin
        state_d = CAL_FAIL ? StFail : StReady;
      end
    end
  end

  // Any command inside the one-cycle shadow of an accepted command is dropped.
  always_comb begin
    acc    = dram_cmd_valid & (state_q == StReady) & ~busy_q & ~dram_rst_i;
    acc_wr = acc & ~dram_cmd_rnw;
    acc_rd = acc & dram_cmd_rnw;
    err_d  = err_q;
    if (dram_cmd_valid && !acc && err_q != 16'hFFFF) begin
      err_d = err_q + 16'd1;
    end
    rd_v_d[0] = acc_rd;
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_v_d[i] = rd_v_q[i-1];
    end
  end

  always_ff @(posedge dram_clk0) begin
    if (dram_rst_i) begin
      state_q   <= StCal;
      cal_cnt_q <= '0;
      busy_q    <= 1'b0;
      wr_hi_q   <= 1'b0;
      err_q     <= '0;
      rd_v_q    <= '0;
      b1_v_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cal_cnt_q <= cal_cnt_d;
      busy_q    <= acc;
      wr_hi_q   <= acc_wr;
      err_q     <= err_d;
      rd_v_q    <= rd_v_d;
      b1_v_q    <= rd_v_q[RD_LATENCY-1];
    end
  end

  // Datapath registers need no reset: their use is qualified by the valid bits above.
  always_ff @(posedge dram_clk0) begin
    wr_addr_q <= cmd_idx;
    b1_d_q    <= rd_d_q[RD_LATENCY-1][BurstW-1:BeatW];
    rd_d_q[0] <= mem[cmd_idx];
    for (int i = 1; i < RD_LATENCY; i++) begin
      rd_d_q[i] <= rd_d_q[i-1];
    end
  end

  // Beat0 lands in the low half on accept; beat1 in the high half one cycle later
  // unless reset intervenes.
  always_ff @(posedge dram_clk0) begin
    for (int b = 0; b < BeW; b++) begin
      if (acc_wr && dram_wr_be[b]) begin
        mem[cmd_idx][b*8 +: 8] <= dram_wr_data[b*8 +: 8];
      end
      if (wr_hi_q && !dram_rst_i && dram_wr_be[b]) begin
        mem[wr_addr_q][BeatW + b*8 +: 8] <= dram_wr_data[b*8 +: 8];
      end
    end
  end

  always_comb begin
    dram_phy_rdy  = (state_q == StReady);
    dram_cal_fail = (state_q == StFail);
    cmd_err_count = err_q;
    dram_rd_valid = 1'b0;
    dram_rd_data  = '0;
    // Gated by reset so undelivered beats vanish from the first reset cycle.
    if (!dram_rst_i) begin
      if (rd_v_q[RD_LATENCY-1]) begin
        dram_rd_valid = 1'b1;
        dram_rd_data  = rd_d_q[RD_LATENCY-1][BeatW-1:0];
      end else if (b1_v_q) begin
        dram_rd_valid = 1'b1;
        dram_rd_data  = b1_d_q;
      end
    end
  end

endmodule

// File: tb/tb_dram_app_responder.sv
// Self-checking bench for dram_app_responder: a burst-level reference model compared every
// cycle, plus directed scenarios with literal expectations. A second instance is built with
// CAL_FAIL=1 to cover failed calibration and error-count saturation.
module tb_dram_app_responder;

  localparam int unsigned BW   = 144;
  localparam int unsigned BEW  = 18;
  localparam int unsigned LAT  = 4;
  localparam int unsigned CAL  = 64;
  localparam int unsigned CAL2 = 10;

  localparam logic [BW-1:0] B0    = {36{4'h1}};
  localparam logic [BW-1:0] B1    = {36{4'hA}};
  localparam logic [BW-1:0] BE_LO = {{136{1'b1}}, 8'h00};
  localparam logic [BW-1:0] BE_HI = {8'h00, {136{1'b1}}};
  localparam logic [BW-1:0] K9L   = {18{8'h99}};
  localparam logic [BW-1:0] K9H   = {18{8'h9C}};
  localparam logic [BW-1:0] L11   = {18{8'hB1}};
  localparam logic [BW-1:0] H11   = {18{8'hB2}};
  localparam logic [BW-1:0] N11L  = {18{8'hC1}};
  localparam logic [BW-1:0] N11H  = {18{8'hC2}};

  logic           clk = 1'b0;
  logic           rst;
  logic           cmd_valid, cmd_rnw;
  logic [31:0]    cmd_addr;
  logic [BW-1:0]  wr_data;
  logic [BEW-1:0] wr_be;
  logic [BW-1:0]  rd_data, rd_data2;
  logic           rd_valid, rd_valid2, phy_rdy, phy_rdy2, cal_fail, cal_fail2;
  logic [15:0]    err, err2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dram_app_responder #(
    .DQ_WIDTH(72), .ADDR_BITS(6), .RD_LATENCY(LAT), .CAL_CYCLES(CAL), .CAL_FAIL(1'b0)
  ) u_dut (
    .dram_clk0(clk), .dram_rst_i(rst), .dram_cmd_valid(cmd_valid), .dram_cmd_rnw(cmd_rnw),
    .dram_cmd_addr(cmd_addr), .dram_wr_data(wr_data), .dram_wr_be(wr_be),
    .dram_rd_data(rd_data), .dram_rd_valid(rd_valid), .dram_phy_rdy(phy_rdy),
    .dram_cal_fail(cal_fail), .cmd_err_count(err)
  );

  dram_app_responder #(
    .DQ_WIDTH(72), .ADDR_BITS(6), .RD_LATENCY(1), .CAL_CYCLES(CAL2), .CAL_FAIL(1'b1)
  ) u_dut_fail (
    .dram_clk0(clk), .dram_rst_i(rst), .dram_cmd_valid(cmd_valid), .dram_cmd_rnw(cmd_rnw),
    .dram_cmd_addr(cmd_addr), .dram_wr_data(wr_data), .dram_wr_be(wr_be),
    .dram_rd_data(rd_data2), .dram_rd_valid(rd_valid2), .dram_phy_rdy(phy_rdy2),
    .dram_cal_fail(cal_fail2), .cmd_err_count(err2)
  );

  task automatic chk(input string nm, input logic [287:0] act, input logic [287:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [BW-1:0] rnd144();
    logic [159:0] t;
    t = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return t[BW-1:0];
  endfunction

  function automatic logic [BW-1:0] merge(input logic [BW-1:0] old, input logic [BW-1:0] d,
                                          input logic [BEW-1:0] be);
    logic [BW-1:0] r;
    r = old;
    for (int b = 0; b < BEW; b++) if (be[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  // ---------------- reference model + per-cycle compare ----------------
  logic [BW-1:0] mlo [64];
  logic [BW-1:0] mhi [64];
  bit            ev [int];           // absolute cycle -> a read beat is due
  logic [BW-1:0] ed [int];           // absolute cycle -> that beat's data
  int            gcyc = 0;
  int            cnt = 0;            // cycles since reset release
  int            merr = 0, merr2 = 0;
  bit            armed = 0, last_acc = 0, wpend = 0;
  logic [5:0]    waddr;

  initial begin
    bit            exp_v, acc;
    logic [BW-1:0] exp_d;
    logic [5:0]    a;
    forever begin
      @(negedge clk);
      if (armed) begin
        exp_v = !rst && ev.exists(gcyc);
        exp_d = exp_v ? ed[gcyc] : '0;
        chk("rd_valid", rd_valid, exp_v);
        chk("rd_data", rd_data, exp_d);
        chk("phy_rdy", phy_rdy, cnt >= CAL);
        chk("cal_fail", cal_fail, 1'b0);
        chk("err_count", err, merr);
        chk("fail_phy_rdy", phy_rdy2, 1'b0);
        chk("fail_cal_fail", cal_fail2, cnt >= CAL2);
        chk("fail_err_count", err2, merr2);
        chk("fail_rd_valid", rd_valid2, 1'b0);
      end
      if (rst) begin
        cnt = 0; merr = 0; merr2 = 0; last_acc = 0; wpend = 0;
        ev.delete(); ed.delete();
        armed = 1;
      end else if (armed) begin
        if (wpend) mhi[waddr] = merge(mhi[waddr], wr_data, wr_be);
        wpend = 0;
        a   = cmd_addr[5:0];
        acc = cmd_valid && cnt >= CAL && !last_acc;
        if (cmd_valid && !acc && merr < 65535) merr++;
        if (cmd_valid && merr2 < 65535) merr2++;
        if (acc && !cmd_rnw) begin
          mlo[a] = merge(mlo[a], wr_data, wr_be);
          wpend  = 1;
          waddr  = a;
        end
        if (acc && cmd_rnw) begin
          ev[gcyc + LAT]     = 1'b1;
          ed[gcyc + LAT]     = mlo[a];
          ev[gcyc + LAT + 1] = 1'b1;
          ed[gcyc + LAT + 1] = mhi[a];
        end
        last_acc = acc;
        if (cnt < 1000000) cnt++;
      end
      if (ev.exists(gcyc)) begin
        ev.delete(gcyc);
        ed.delete(gcyc);
      end
      gcyc++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic issue(input bit rnw, input logic [31:0] a, input logic [BW-1:0] d,
                       input logic [BEW-1:0] be);
    cmd_valid = 1'b1;
    cmd_rnw   = rnw;
    cmd_addr  = a;
    wr_data   = d;
    wr_be     = be;
  endtask

  task automatic wr(input logic [31:0] a, input logic [BW-1:0] lo, input logic [BW-1:0] hi,
                    input logic [BEW-1:0] be_lo, input logic [BEW-1:0] be_hi);
    issue(1'b0, a, lo, be_lo);
    cyc();
    wr_data = hi;
    wr_be   = be_hi;
    cyc();
  endtask

  task automatic rd_expect(input string nm, input logic [31:0] a, input logic [BW-1:0] lo,
                           input logic [BW-1:0] hi);
    issue(1'b1, a, '0, '0);
    for (int k = 1; k <= LAT + 2; k++) begin
      cyc();
      @(negedge clk);
      if (k == LAT - 1) chk({nm, "_early"}, rd_valid, 1'b0);
      if (k == LAT) begin
        chk({nm, "_v0"}, rd_valid, 1'b1);
        chk({nm, "_beat0"}, rd_data, lo);
      end
      if (k == LAT + 1) begin
        chk({nm, "_v1"}, rd_valid, 1'b1);
        chk({nm, "_beat1"}, rd_data, hi);
      end
      if (k == LAT + 2) chk({nm, "_end"}, rd_valid, 1'b0);
    end
    cyc();
  endtask

  initial begin
    logic [BW-1:0] seq [6];
    rst = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_addr = '0; wr_data = '0; wr_be = '0;
    repeat (3) cyc();
    rst = 1'b0;

    // Calibration with three early (dropped) commands.
    for (int i = 0; i <= 64; i++) begin
      if (i == 5 || i == 10 || i == 15) issue(1'b0, 32'd7, '0, '1);
      if (i == 9 || i == 10) begin
        @(negedge clk);
        chk("fail_cal_edge", cal_fail2, i == 10);
      end
      if (i == 63) begin
        @(negedge clk);
        chk("phy_rdy_63", phy_rdy, 1'b0);
      end
      if (i == 64) begin
        @(negedge clk);
        chk("phy_rdy_64", phy_rdy, 1'b1);
        chk("err_pre_ready", err, 16'd3);
      end
      cyc();
    end

    // Give every RAM word known contents.
    for (int a = 0; a < 64; a++) wr(a, rnd144(), rnd144(), '1, '1);

    wr(5, B0, B1, '1, '1);
    rd_expect("wr_rd5", 5, B0, B1);

    wr(3, '1, '1, '1, '1);
    wr(3, '0, '0, 18'h00001, 18'h20000);
    rd_expect("byte_en", 3, BE_LO, BE_HI);

    for (int k = 1; k <= 3; k++) begin
      seq[2*k-2] = {18{8'(k)}};
      seq[2*k-1] = {18{8'(k + 8'h80)}};
      wr(k, seq[2*k-2], seq[2*k-1], '1, '1);
    end
    wr(9, K9L, K9H, '1, '1);
    wr(11, L11, H11, '1, '1);

    // Back-to-back reads with an illegal command squeezed in at t+1.
    for (int k = 0; k <= 10; k++) begin
      case (k)
        0:       issue(1'b1, 32'd1, '0, '0);
        1, 2:    issue(1'b1, 32'd2, '0, '0);
        4:       issue(1'b1, 32'd3, '0, '0);
        default: ;
      endcase
      @(negedge clk);
      if (k == 2) chk("b2b_err", err, 16'd4);
      if (k >= 4 && k <= 9) begin
        chk("b2b_valid", rd_valid, 1'b1);
        chk("b2b_data", rd_data, seq[k-4]);
      end
      if (k == 10) chk("b2b_end", rd_valid, 1'b0);
      cyc();
    end

    // Reset two cycles into a read: no beats may appear.
    issue(1'b1, 32'd5, '0, '0);
    cyc();
    cyc();
    rst = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      if (k == 4) rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_read", rd_valid, 1'b0);
      cyc();
    end
    for (int rc = 5; rc <= 64; rc++) begin
      if (rc == 5 || rc == 10 || rc == 15) issue(1'b0, 32'd9, '0, '1);
      if (rc == 64) begin
        @(negedge clk);
        chk("recal_rdy", phy_rdy, 1'b1);
        chk("recal_err", err, 16'd3);
      end
      cyc();
    end
    rd_expect("ram_kept", 32'h0000_0049, K9L, K9H);

    // Reset between write beats: low half new, high half old.
    issue(1'b0, 32'd11, N11L, '1);
    cyc();
    rst = 1'b1;
    wr_data = N11H;
    cyc();
    rst = 1'b0;
    for (int i = 0; i < 65; i++) cyc();
    rd_expect("rst_beat1", 32'd11, N11L, H11);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 999) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      cmd_valid = ($urandom_range(0, 9) < 6);
      cmd_rnw   = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      wr_data   = rnd144();
      wr_be     = ($urandom_range(0, 1) == 1) ? '1 : 18'($urandom);
      cyc();
    end

    // Continuous strobes: the failed instance drops all of them and must saturate.
    for (int i = 0; i < 65600; i++) begin
      cmd_valid = 1'b1;
      cmd_rnw   = 1'($urandom_range(0, 1));
      cmd_addr  = $urandom;
      wr_data   = rnd144();
      wr_be     = 18'($urandom);
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("err_saturate", err2, 16'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
